vram_scan_arbiter: RTL and testbench
====================================

// Module: vram_scan_arbiter
// PURPOSE
// Shares one single-port video SRAM between the CPU bus and scanout line prefetch.
// On each line_start pulse from the timing generator it fetches one line of pixel
// words into a ping-pong line buffer. CPU accesses interleave under a starvation bound.
// Sits between picosoc memory mux, video SRAM controller and the pixel output stage.
// PARAMETERS
// ADDR_W          18   word-aligned byte address width of video SRAM
// WORDS_PER_LINE  160  32-bit words fetched per line (640 px, 8 bpp)
// LB_AW           8    line-buffer word address width; needs 2**LB_AW >= WORDS_PER_LINE
// BURST_MAX       8    max consecutive video words before a pending CPU access is granted
// PORTS
// clk             in   1       system clock
// reset           in   1       asynchronous, active-high reset
// fb_base         in   ADDR_W  frame base byte address; sampled on frame_start
// frame_start     in   1       1-cycle pulse before first active line of a frame
// line_start      in   1       1-cycle pulse: fetch next line now
// cpu_valid       in   1       CPU request, held until cpu_ready
// cpu_ready       out  1       1-cycle completion strobe
// cpu_addr        in   ADDR_W  CPU byte address
// cpu_wdata       in   32      CPU write data
// cpu_wstrb       in   4       byte strobes; 0 = read
// cpu_rdata       out  32      read data, valid with cpu_ready
// mem_req         out  1       SRAM request, held until mem_ack
// mem_addr        out  ADDR_W  SRAM byte address
// mem_wdata       out  32      SRAM write data
// mem_wstrb       out  4       SRAM byte strobes; 0 = read
// mem_rdata       in   32      SRAM read data, valid with mem_ack
// mem_ack         in   1       1-cycle completion, >=1 cycle after mem_req rises
// lb_we           out  1       line-buffer write enable
// lb_addr         out  LB_AW+1 {bank, word index}
// lb_wdata        out  32      line-buffer write data
// rd_bank         out  1       bank scanout must read (last completed bank)
// underrun        out  16      lines whose fetch missed deadline (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all outputs 0; FSM IDLE; line_addr=0; bank=0; no fetch pending.
// - FSM: IDLE, CPU (access in flight), VID (video word in flight).
// - frame_start: line_addr <= fb_base; bank <= 0. line_start: set vid_pend,
//   word_idx <= 0; fetch address = line_addr; after last word line_addr += WORDS_PER_LINE*4.
// - Arbitration in IDLE: vid_pend wins unless burst_cnt == BURST_MAX and cpu_valid,
//   then CPU wins and burst_cnt <= 0. burst_cnt counts consecutive video grants; cleared
//   on any CPU grant or when vid_pend clears. No vid_pend: cpu_valid granted.
// - Grant to request: mem_req rises the cycle after grant; address/data/strobe stable
//   while mem_req high. mem_ack drops mem_req same edge; FSM returns to IDLE.
// - CPU: on mem_ack, cpu_ready=1 one cycle, cpu_rdata=mem_rdata (write: don't care).
//   Min CPU latency 2 cycles after cpu_valid with idle SRAM.
// - VID: on mem_ack, lb_we=1 one cycle, lb_addr={bank,word_idx}, lb_wdata=mem_rdata;
//   word_idx++. Last word (WORDS_PER_LINE-1): vid_pend<=0, rd_bank<=bank, bank toggles.
// - Simultaneous frame_start and line_start: frame_start applied first, fetch uses fb_base.
// - line_start while vid_pend (deadline miss): abandon old line (no rd_bank swap),
//   restart at word 0 of the next line; in-flight mem access still completes and is
//   written to the old index; line_addr advances by one stride for the skipped line.
// - mem_ack never expected outside mem_req; ignored if seen.
// - Reset mid-access: mem_req drops asynchronously; CPU sees no cpu_ready.
// - Address wrap: line_addr arithmetic modulo 2**ADDR_W.
// CONFIGURATION
// VRAM_SCAN_ARB_STATS_EN defined: underrun increments on each deadline miss,
//   saturates at 16'hFFFF, cleared only by reset.
// Not defined: underrun tied to 0, counter logic absent; behaviour otherwise identical.
// TESTING
// 1 Reset held, random inputs -> all outputs 0; release -> IDLE, no mem_req.
// 2 fb_base=0x1000, frame_start, line_start, 1-cycle ack SRAM -> 160 lb_we,
//   addrs 0x1000..0x127C, lb_addr 0..159 bank0, then rd_bank=0; next line from 0x1280 bank1.
// 3 cpu_valid held during fetch -> CPU granted after each 8 video words; cpu_rdata matches.
// 4 CPU write wstrb=4'b0011, no fetch -> mem_wstrb=4'b0011, cpu_ready 1 cycle after ack.
// 5 line_start at word 50 -> restart word 0 at base+stride, rd_bank unchanged,
//   underrun=1 with VRAM_SCAN_ARB_STATS_EN, 0 without.
// 6 reset asserted with mem_req high -> mem_req 0 immediately, no cpu_ready or lb_we.

Source files
------------

// File: rtl/vram_scan_arbiter.sv
// Single-port video SRAM arbiter: CPU bus accesses interleaved with per-line scanout prefetch
// into a ping-pong line buffer. Define VRAM_SCAN_ARB_STATS_EN to enable the underrun counter.
module vram_scan_arbiter #(
    parameter int ADDR_W         = 18,
    parameter int WORDS_PER_LINE = 160,
    parameter int LB_AW          = 8,
    parameter int BURST_MAX      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic [31:0]       cpu_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              lb_we,
    output logic [LB_AW:0]    lb_addr,
    output logic [31:0]       lb_wdata,
    output logic              rd_bank,
    output logic [15:0]       underrun
);

    localparam int              BW        = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0]     BURST_LIM = BW'(BURST_MAX);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(WORDS_PER_LINE * 4);
    localparam logic [LB_AW-1:0]  LAST_IDX  = LB_AW'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, CPU, VID} state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] line_addr;
    logic [ADDR_W-1:0] fetch_addr;
    logic              bank;
    logic              vid_pend;
    logic              stale;
    logic [LB_AW-1:0]  word_idx;
    logic [LB_AW-1:0]  vid_idx;
    logic              vid_bank;
    logic [BW-1:0]     burst_cnt;

    logic              cpu_pend;
    logic              vid_ok;
    logic              grant_vid;
    logic              grant_cpu;
    logic              ack_cpu;
    logic              ack_vid;
    logic              vid_fresh;
    logic              line_done;
    logic              miss;

    // A CPU request whose cpu_ready is showing this cycle is already served, so it
    // must not be granted again. Video grants wait out start pulses so the fetch
    // address is always taken from the settled line base.
    always_comb begin
        cpu_pend   = cpu_valid && !cpu_ready;
        vid_ok     = vid_pend && !line_start && !frame_start;
        grant_vid  = (state == IDLE) && vid_ok && !((burst_cnt == BURST_LIM) && cpu_pend);
        grant_cpu  = (state == IDLE) && !grant_vid && cpu_pend;
        ack_cpu    = (state == CPU) && mem_ack;
        ack_vid    = (state == VID) && mem_ack;
        vid_fresh  = ack_vid && !stale;
        line_done  = vid_fresh && (word_idx == LAST_IDX);
        miss       = line_start && vid_pend && !line_done;
        fetch_addr = line_addr + ADDR_W'({word_idx, 2'b00});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_vid) begin
                    state_nxt = VID;
                end else if (grant_cpu) begin
                    state_nxt = CPU;
                end
            end
            CPU, VID: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            vid_idx   <= '0;
            vid_bank  <= 1'b0;
        end else if (grant_vid) begin
            mem_addr  <= fetch_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            vid_idx   <= word_idx;
            vid_bank  <= bank;
        end else if (grant_cpu) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_wstrb <= cpu_wstrb;
        end
    end

    // Completed words land at the index captured at grant time, so a word still
    // in flight across an abandoned line goes to its original slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            lb_we     <= 1'b0;
            lb_addr   <= '0;
            lb_wdata  <= '0;
        end else begin
            cpu_ready <= ack_cpu;
            lb_we     <= ack_vid;
            if (ack_cpu) begin
                cpu_rdata <= mem_rdata;
            end
            if (ack_vid) begin
                lb_addr  <= {vid_bank, vid_idx};
                lb_wdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_addr <= '0;
            bank      <= 1'b0;
            rd_bank   <= 1'b0;
            vid_pend  <= 1'b0;
            word_idx  <= '0;
            stale     <= 1'b0;
        end else begin
            if (frame_start) begin
                line_addr <= fb_base;
            end else if (miss || line_done) begin
                line_addr <= line_addr + STRIDE;
            end

            if (frame_start) begin
                bank <= 1'b0;
            end else if (line_done) begin
                bank <= ~bank;
            end

            if (line_done) begin
                rd_bank <= bank;
            end

            if (line_start) begin
                vid_pend <= 1'b1;
                word_idx <= '0;
            end else if (line_done) begin
                vid_pend <= 1'b0;
            end else if (vid_fresh) begin
                word_idx <= word_idx + 1'b1;
            end

            if (ack_vid) begin
                stale <= 1'b0;
            end else if ((state == VID) && line_start) begin
                stale <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_cnt <= '0;
        end else if (grant_cpu || line_done) begin
            burst_cnt <= '0;
        end else if (grant_vid && (burst_cnt != BURST_LIM)) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

`ifdef VRAM_SCAN_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun <= '0;
        end else if (miss && (underrun != 16'hFFFF)) begin
            underrun <= underrun + 16'd1;
        end
    end
`else
    assign underrun = '0;
`endif

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Directed self-checking bench for vram_scan_arbiter with a one-cycle-ack SRAM model
// and a monitor that logs line-buffer writes and SRAM request starts.
module tb_vram_scan_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [17:0] fb_base = '0;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic        cpu_valid = 1'b0;
    logic        cpu_ready;
    logic [17:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_wstrb = '0;
    logic [31:0] cpu_rdata;
    logic        mem_req;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        lb_we;
    logic [8:0]  lb_addr;
    logic [31:0] lb_wdata;
    logic        rd_bank;
    logic [15:0] underrun;

    logic        ack_en = 1'b1;
    logic        req_prev = 1'b0;
    int          checks = 0;
    int          failures = 0;

    logic [8:0]  lb_addr_q[$];
    logic [31:0] lb_data_q[$];
    logic [17:0] req_addr_q[$];
    logic [3:0]  req_strb_q[$];
    logic [31:0] req_wdata_q[$];

    vram_scan_arbiter dut (
        .clk(clk), .reset(reset), .fb_base(fb_base), .frame_start(frame_start),
        .line_start(line_start), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_rdata(cpu_rdata), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
        .rd_bank(rd_bank), .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sram_word(input logic [17:0] a);
        return {14'h2A5A, a};
    endfunction

    // SRAM answers every request one cycle after it rises
    always @(posedge clk) begin
        #1;
        mem_ack   = ack_en && mem_req;
        mem_rdata = sram_word(mem_addr);
    end

    always @(negedge clk) begin
        if (lb_we) begin
            lb_addr_q.push_back(lb_addr);
            lb_data_q.push_back(lb_wdata);
        end
        if (mem_req && !req_prev) begin
            req_addr_q.push_back(mem_addr);
            req_strb_q.push_back(mem_wstrb);
            req_wdata_q.push_back(mem_wdata);
        end
        req_prev = mem_req;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        lb_addr_q.delete();
        lb_data_q.delete();
        req_addr_q.delete();
        req_strb_q.delete();
        req_wdata_q.delete();
    endtask

    task automatic wait_lb(input int n, input int limit, input string name);
        int k;
        k = 0;
        while (lb_addr_q.size() < n && k < limit) begin
            tick();
            k++;
        end
        checks++;
        if (lb_addr_q.size() < n) begin
            failures++;
            $display("[TB] FAIL %s timeout: lb writes=%0d required=%0d", name, lb_addr_q.size(), n);
        end
    endtask

    task automatic check_line(input int first, input logic bnk, input logic [17:0] base, input string name);
        for (int i = 0; i < 160; i++) begin
            checks++;
            if (lb_addr_q[first+i] !== {bnk, 8'(i)} || lb_data_q[first+i] !== sram_word(base + 18'(4*i))) begin
                failures++;
                $display("[TB] FAIL %s word %0d: lb_addr=%h data=%h required lb_addr=%h data=%h", name, i,
                         lb_addr_q[first+i], lb_data_q[first+i], {bnk, 8'(i)}, sram_word(base + 18'(4*i)));
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            fb_base = 18'($urandom); frame_start = 1'($urandom); line_start = 1'($urandom);
            cpu_valid = 1'($urandom); cpu_addr = 18'($urandom); cpu_wdata = $urandom;
            cpu_wstrb = 4'($urandom);
            tick();
            checks++;
            if ({cpu_ready, cpu_rdata, mem_req, mem_addr, mem_wdata, mem_wstrb, lb_we, lb_addr,
                 lb_wdata, rd_bank, underrun} !== '0) begin
                failures++;
                $display("[TB] FAIL reset_outputs cycle %0d: mem_req=%b lb_we=%b cpu_ready=%b required all 0",
                         i, mem_req, lb_we, cpu_ready);
            end
        end
        fb_base = '0; frame_start = 0; line_start = 0; cpu_valid = 0;
        cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (mem_req !== 1'b0 || lb_we !== 1'b0) begin
                failures++;
                $display("[TB] FAIL release_idle: mem_req=%b lb_we=%b required 0 0", mem_req, lb_we);
            end
        end
    endtask

    task automatic test_line_fetch();
        clear_logs();
        fb_base = 18'h1000; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; line_start = 1'b1;
        tick();
        line_start = 1'b0;
        wait_lb(160, 1000, "line0");
        repeat (3) tick();
        check_line(0, 1'b0, 18'h1000, "line0");
        checks++;
        if (req_addr_q.size() != 160 || req_addr_q[0] !== 18'h1000 || req_addr_q[159] !== 18'h127C) begin
            failures++;
            $display("[TB] FAIL line0_addrs: count=%0d first=%h last=%h required 160 01000 0127c",
                     req_addr_q.size(), req_addr_q[0], req_addr_q[159]);
        end
        checks++;
        if (rd_bank !== 1'b0 || lb_addr_q.size() != 160) begin
            failures++;
            $display("[TB] FAIL line0_done: rd_bank=%b writes=%0d required 0 160", rd_bank, lb_addr_q.size());
        end
        clear_logs();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        wait_lb(160, 1000, "line1");
        repeat (3) tick();
        check_line(0, 1'b1, 18'h1280, "line1");
        checks++;
        if (rd_bank !== 1'b1 || req_addr_q[0] !== 18'h1280) begin
            failures++;
            $display("[TB] FAIL line1_done: rd_bank=%b first_addr=%h required 1 01280", rd_bank, req_addr_q[0]);
        end
    endtask

    task automatic test_cpu_interleave();
        int n;
        int k;
        logic [17:0] exp_addr;
        clear_logs();
        n = 0;
        k = 0;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        cpu_valid = 1'b1; cpu_addr = 18'h3000; cpu_wstrb = 4'b0000;
        while ((lb_addr_q.size() < 160 || n < 5) && k < 2000) begin
            tick();
            k++;
            if (cpu_valid && cpu_ready) begin
                checks++;
                if (cpu_rdata !== sram_word(cpu_addr)) begin
                    failures++;
                    $display("[TB] FAIL cpu_rdata %0d: got=%h required=%h", n, cpu_rdata, sram_word(cpu_addr));
                end
                n++;
                if (n == 5) cpu_valid = 1'b0;
                else cpu_addr = cpu_addr + 18'd4;
            end
        end
        checks++;
        if (n != 5 || lb_addr_q.size() != 160 || req_addr_q.size() != 165) begin
            failures++;
            $display("[TB] FAIL interleave_counts: cpu=%0d lb=%0d reqs=%0d required 5 160 165",
                     n, lb_addr_q.size(), req_addr_q.size());
        end
        for (int p = 0; p < 45; p++) begin
            if (p % 9 == 8) exp_addr = 18'h3000 + 18'(4 * (p / 9));
            else exp_addr = 18'h1500 + 18'(4 * (8 * (p / 9) + p % 9));
            checks++;
            if (req_addr_q[p] !== exp_addr) begin
                failures++;
                $display("[TB] FAIL grant_order slot %0d: addr=%h required=%h", p, req_addr_q[p], exp_addr);
            end
        end
        check_line(0, 1'b0, 18'h1500, "line2");
    endtask

    task automatic test_cpu_write();
        int ack_cyc;
        int rdy_cyc;
        int rdy_cnt;
        clear_logs();
        ack_cyc = -1; rdy_cyc = -1; rdy_cnt = 0;
        cpu_valid = 1'b1; cpu_addr = 18'h2000; cpu_wdata = 32'hDEADBEEF; cpu_wstrb = 4'b0011;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (mem_ack && ack_cyc < 0) ack_cyc = k;
            if (cpu_ready) begin
                rdy_cnt++;
                if (rdy_cyc < 0) rdy_cyc = k;
                cpu_valid = 1'b0;
            end
        end
        checks++;
        if (req_addr_q.size() != 1 || req_addr_q[0] !== 18'h2000 || req_strb_q[0] !== 4'b0011 ||
            req_wdata_q[0] !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL cpu_write_bus: reqs=%0d addr=%h strb=%b data=%h required 1 02000 0011 deadbeef",
                     req_addr_q.size(), req_addr_q[0], req_strb_q[0], req_wdata_q[0]);
        end
        checks++;
        if (rdy_cyc != 2 || ack_cyc != 1 || rdy_cnt != 1) begin
            failures++;
            $display("[TB] FAIL cpu_write_timing: ack=%0d ready=%0d pulses=%0d required 1 2 1",
                     ack_cyc, rdy_cyc, rdy_cnt);
        end
        checks++;
        if (lb_addr_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL cpu_write_no_lb: lb writes=%0d required 0", lb_addr_q.size());
        end
        cpu_wstrb = 4'b0000; cpu_wdata = '0;
    endtask

    task automatic test_deadline_miss();
        logic [15:0] exp_under;
`ifdef VRAM_SCAN_ARB_STATS_EN
        exp_under = 16'd1;
`else
        exp_under = 16'd0;
`endif
        clear_logs();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        wait_lb(50, 400, "miss_first50");
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        checks++;
        if (rd_bank !== 1'b0 || underrun !== exp_under) begin
            failures++;
            $display("[TB] FAIL miss_state: rd_bank=%b underrun=%0d required 0 %0d", rd_bank, underrun, exp_under);
        end
        wait_lb(210, 1000, "miss_restart");
        repeat (4) tick();
        check_line(50, 1'b1, 18'h1A00, "restart");
        checks++;
        if (lb_addr_q.size() != 210 || req_addr_q[50] !== 18'h1A00 || req_addr_q[209] !== 18'h1C7C) begin
            failures++;
            $display("[TB] FAIL restart_addrs: writes=%0d first=%h last=%h required 210 01a00 01c7c",
                     lb_addr_q.size(), req_addr_q[50], req_addr_q[209]);
        end
        checks++;
        if (rd_bank !== 1'b1 || underrun !== exp_under) begin
            failures++;
            $display("[TB] FAIL restart_done: rd_bank=%b underrun=%0d required 1 %0d", rd_bank, underrun, exp_under);
        end
    endtask

    task automatic test_reset_mid_access();
        ack_en = 1'b0;
        cpu_valid = 1'b1; cpu_addr = 18'h0400;
        tick();
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stuck_req: mem_req=%b required 1", mem_req);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || cpu_ready !== 1'b0 || lb_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_drop: mem_req=%b cpu_ready=%b lb_we=%b required 0 0 0",
                     mem_req, cpu_ready, lb_we);
        end
        ack_en = 1'b1;
        cpu_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if (underrun !== 16'd0 || rd_bank !== 1'b0 || mem_addr !== '0) begin
            failures++;
            $display("[TB] FAIL reset_clear: underrun=%0d rd_bank=%b mem_addr=%h required 0 0 0",
                     underrun, rd_bank, mem_addr);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (cpu_ready !== 1'b0 || lb_we !== 1'b0 || mem_req !== 1'b0) begin
                failures++;
                $display("[TB] FAIL post_reset_quiet: cpu_ready=%b lb_we=%b mem_req=%b required 0 0 0",
                         cpu_ready, lb_we, mem_req);
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_fetch();
        test_cpu_interleave();
        test_cpu_write();
        test_deadline_miss();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
